// File: rtl/reversi_move_sequencer.sv
// Purpose: validates one Reversi move against a 64-cell board and applies the flips and placement.
// Latency: 2 cycles for an occupied target, otherwise 1 + per-direction walk/flip cycles + place + done.
// Backpressure: none; go is only honoured in IDLE and ignored while busy, board reads are same-cycle.
module reversi_move_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       set_black,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       legal,
  output logic [4:0] flip_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIR_INIT, S_SCAN, S_FLIP, S_NEXT_DIR, S_PLACE, S_DONE
  } state_t;

  localparam logic [1:0] CELL_BLACK = 2'd2;
  localparam logic [1:0] CELL_WHITE = 2'd3;

  state_t            state_q, state_d;
  logic [2:0]        tx_q, tx_d;
  logic [2:0]        ty_q, ty_d;
  logic              black_q, black_d;
  logic [2:0]        dir_q, dir_d;
  logic signed [3:0] wx_q, wx_d;
  logic signed [3:0] wy_q, wy_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        k_q, k_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              legal_q, legal_d;

  logic signed [3:0] dx, dy;
  logic signed [3:0] tx_s, ty_s;
  logic [1:0]        own_col, opp_col;
  logic              walk_out;

  // Unit step for the current direction, clockwise from north (dy=-1 is north).
  always_comb begin
    dx = 4'sd0;
    dy = 4'sd0;
    case (dir_q)
      3'd0: begin dx =  4'sd0; dy = -4'sd1; end
      3'd1: begin dx =  4'sd1; dy = -4'sd1; end
      3'd2: begin dx =  4'sd1; dy =  4'sd0; end
      3'd3: begin dx =  4'sd1; dy =  4'sd1; end
      3'd4: begin dx =  4'sd0; dy =  4'sd1; end
      3'd5: begin dx = -4'sd1; dy =  4'sd1; end
      3'd6: begin dx = -4'sd1; dy =  4'sd0; end
      default: begin dx = -4'sd1; dy = -4'sd1; end
    endcase
  end

  // Colour decode and board-edge detect; walk stays within -1..8, so bit 3 flags off-board.
  always_comb begin
    own_col  = black_q ? CELL_BLACK : CELL_WHITE;
    opp_col  = black_q ? CELL_WHITE : CELL_BLACK;
    tx_s     = $signed({1'b0, tx_q});
    ty_s     = $signed({1'b0, ty_q});
    walk_out = wx_q[3] | wy_q[3];
  end

  // Next-state, datapath updates and board port drive.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    black_d = black_q;
    dir_d   = dir_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    run_d   = run_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    legal_d = legal_q;
    rd_addr = 6'd0;
    wr_en   = 1'b0;
    wr_addr = 6'd0;
    wr_data = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          tx_d    = x;
          ty_d    = y;
          black_d = set_black;
          cnt_d   = 5'd0;
          legal_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        rd_addr = {ty_q, tx_q};
        // Codes 2 and 3 are discs; 0 and 1 are free cells.
        if (rd_data[1]) begin
          legal_d = 1'b0;
          state_d = S_DONE;
        end else begin
          dir_d   = 3'd0;
          state_d = S_DIR_INIT;
        end
      end
      S_DIR_INIT: begin
        wx_d    = tx_s + dx;
        wy_d    = ty_s + dy;
        run_d   = 3'd0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        rd_addr = {wy_q[2:0], wx_q[2:0]};
        if (walk_out) begin
          state_d = S_NEXT_DIR;
        end else if (rd_data == opp_col) begin
          run_d = run_q + 3'd1;
          wx_d  = wx_q + dx;
          wy_d  = wy_q + dy;
        end else if (rd_data == own_col) begin
          if (run_q == 3'd0) begin
            state_d = S_NEXT_DIR;
          end else begin
            // Rewind to the first bracketed disc and flip outward.
            wx_d    = tx_s + dx;
            wy_d    = ty_s + dy;
            k_d     = 3'd1;
            state_d = S_FLIP;
          end
        end else begin
          state_d = S_NEXT_DIR;
        end
      end
      S_FLIP: begin
        wr_en   = 1'b1;
        wr_addr = {wy_q[2:0], wx_q[2:0]};
        wr_data = own_col;
        if (k_q == run_q) begin
          cnt_d   = cnt_q + 5'(run_q);
          state_d = S_NEXT_DIR;
        end else begin
          wx_d = wx_q + dx;
          wy_d = wy_q + dy;
          k_d  = k_q + 3'd1;
        end
      end
      S_NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          if (cnt_q != 5'd0) begin
            state_d = S_PLACE;
          end else begin
            legal_d = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = S_DIR_INIT;
        end
      end
      S_PLACE: begin
        wr_en   = 1'b1;
        wr_addr = {ty_q, tx_q};
        wr_data = own_col;
        legal_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any move in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tx_q    <= 3'd0;
      ty_q    <= 3'd0;
      black_q <= 1'b0;
      dir_q   <= 3'd0;
      wx_q    <= 4'sd0;
      wy_q    <= 4'sd0;
      run_q   <= 3'd0;
      k_q     <= 3'd0;
      cnt_q   <= 5'd0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      black_q <= black_d;
      dir_q   <= dir_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      run_q   <= run_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      legal_q <= legal_d;
    end
  end

  // Status outputs; legal and flip_cnt hold their last result outside DONE.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    legal    = legal_q;
    flip_cnt = cnt_q;
  end

endmodule

// File: tb/tb_reversi_move_sequencer.sv
// Purpose: directed checks of reversi_move_sequencer against a behavioural board memory.
// Latency: each move is run to its done pulse under a cycle budget.
// Backpressure: not applicable; go pulses are issued and a mid-move go is checked to be ignored.
module tb_reversi_move_sequencer;

  logic       clk;
  logic       resetn;
  logic       go;
  logic [2:0] x;
  logic [2:0] y;
  logic       set_black;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       busy;
  logic       done;
  logic       legal;
  logic [4:0] flip_cnt;

  reversi_move_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .x         (x),
    .y         (y),
    .set_black (set_black),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .legal     (legal),
    .flip_cnt  (flip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory: whole-board load from preset, otherwise DUT writes, each logged as {addr,data}.
  logic [1:0] board  [64];
  logic [1:0] preset [64];
  logic [7:0] wr_log [32];
  int         wr_n;
  logic       load;

  assign rd_data = board[rd_addr];

  always @(posedge clk) begin
    if (load) begin
      board <= preset;
      wr_n  <= 0;
    end else if (wr_en) begin
      board[wr_addr] <= wr_data;
      if (wr_n < 32) wr_log[wr_n] <= {wr_addr, wr_data};
      wr_n <= wr_n + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_preset();
    for (int i = 0; i < 64; i++) preset[i] = 2'd0;
  endtask

  // Standard opening: W at (x3,y3),(x4,y4); B at (x3,y4),(x4,y3).
  task automatic start_preset();
    clear_preset();
    preset[27] = 2'd3;
    preset[36] = 2'd3;
    preset[35] = 2'd2;
    preset[28] = 2'd2;
  endtask

  task automatic load_board();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Issue a move and wait (bounded) for done; optionally pulse go again while busy.
  task automatic do_move(input logic [2:0] mx, input logic [2:0] my, input logic mb,
                         input logic mid_go, output int cyc, output logic seen,
                         output logic lg, output logic [4:0] fc, output logic [5:0] rd0);
    go = 1'b1; x = mx; y = my; set_black = mb;
    tick();
    go = 1'b0;
    cyc = 1; seen = 1'b0; lg = 1'b0; fc = 5'd0;
    rd0 = rd_addr;
    while (!seen && cyc < 400) begin
      if (done) begin
        seen = 1'b1;
        lg   = legal;
        fc   = flip_cnt;
      end else begin
        if (mid_go && cyc == 3) begin
          go = 1'b1; x = 3'd0; y = 3'd0; set_black = ~mb;
        end else begin
          go = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    go = 1'b0;
  endtask

  int         cyc;
  logic       seen;
  logic       lg;
  logic [4:0] fc;
  logic [5:0] rd0;
  int         n;

  initial begin
    resetn = 1'b0; go = 1'b0; x = 3'd0; y = 3'd0; set_black = 1'b0; load = 1'b0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_legal", legal, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_flip_cnt", flip_cnt, 5'd0);
    check("rst_rd_addr", rd_addr, 6'd0);
    check("rst_wr_addr", wr_addr, 6'd0);
    check("rst_wr_data", wr_data, 2'd0);
    tick(); tick();
    resetn = 1'b1;
    check("release_wr_en", wr_en, 1'b0);

    // Opening move for black at (x3,y2): single flip southward.
    start_preset(); load_board();
    do_move(3'd3, 3'd2, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("open_done_seen", seen, 1'b1);
    check("open_check_addr", rd0, 6'h13);
    check("open_cycles", cyc, 29);
    check("open_legal", lg, 1'b1);
    check("open_flip_cnt", fc, 5'd1);
    check("open_nwr", wr_n, 2);
    check("open_wr0", wr_log[0], {6'h1B, 2'd2});
    check("open_wr1", wr_log[1], {6'h13, 2'd2});
    tick();
    check("open_done_pulse", done, 1'b0);
    check("open_idle", busy, 1'b0);

    // Occupied target: rejected straight from CHECK.
    start_preset(); load_board();
    do_move(3'd3, 3'd3, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("occ_done_seen", seen, 1'b1);
    check("occ_check_addr", rd0, 6'h1B);
    check("occ_cycles", cyc, 2);
    check("occ_legal", lg, 1'b0);
    check("occ_flip_cnt", fc, 5'd0);
    check("occ_nwr", wr_n, 0);

    // Corner with no neighbours: every direction falls through.
    start_preset(); load_board();
    do_move(3'd0, 3'd0, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("corner_done_seen", seen, 1'b1);
    check("corner_legal", lg, 1'b0);
    check("corner_flip_cnt", fc, 5'd0);
    check("corner_nwr", wr_n, 0);

    // White moves onto an ENABLE cell at (x4,y2): flips (x4,y3).
    start_preset(); preset[20] = 2'd1; load_board();
    do_move(3'd4, 3'd2, 1'b0, 1'b0, cyc, seen, lg, fc, rd0);
    check("white_legal", lg, 1'b1);
    check("white_flip_cnt", fc, 5'd1);
    check("white_nwr", wr_n, 2);
    check("white_wr0", wr_log[0], {6'h1C, 2'd3});
    check("white_wr1", wr_log[1], {6'h14, 2'd3});

    // ENABLE between target and own disc does not count as an opponent.
    clear_preset(); preset[1] = 2'd1; preset[2] = 2'd2; load_board();
    do_move(3'd0, 3'd0, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("enable_legal", lg, 1'b0);
    check("enable_nwr", wr_n, 0);

    // Row 0: six white discs bracketed by black at x7.
    clear_preset();
    for (int i = 1; i <= 6; i++) preset[i] = 2'd3;
    preset[7] = 2'd2;
    load_board();
    do_move(3'd0, 3'd0, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("row_legal", lg, 1'b1);
    check("row_flip_cnt", fc, 5'd6);
    check("row_nwr", wr_n, 7);
    for (int i = 0; i < 6; i++) check("row_flip_wr", wr_log[i], {6'(i + 1), 2'd2});
    check("row_place_wr", wr_log[6], {6'h00, 2'd2});

    // Same row ending on an empty cell, then running off the board edge.
    preset[7] = 2'd0; load_board();
    do_move(3'd0, 3'd0, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("row_empty_legal", lg, 1'b0);
    check("row_empty_nwr", wr_n, 0);
    preset[7] = 2'd3; load_board();
    do_move(3'd0, 3'd0, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("row_edge_legal", lg, 1'b0);
    check("row_edge_flip_cnt", fc, 5'd0);
    check("row_edge_nwr", wr_n, 0);

    // Target (x2,y2): E run of 2, SE run of 3, S run of 1; stray go while busy.
    clear_preset();
    preset[19] = 2'd3; preset[20] = 2'd3; preset[21] = 2'd2;
    preset[26] = 2'd3; preset[34] = 2'd2;
    preset[27] = 2'd3; preset[36] = 2'd3; preset[45] = 2'd3; preset[54] = 2'd2;
    load_board();
    do_move(3'd2, 3'd2, 1'b1, 1'b1, cyc, seen, lg, fc, rd0);
    check("multi_done_seen", seen, 1'b1);
    check("multi_legal", lg, 1'b1);
    check("multi_flip_cnt", fc, 5'd6);
    check("multi_nwr", wr_n, 7);
    check("multi_wr0", wr_log[0], {6'h13, 2'd2});
    check("multi_wr1", wr_log[1], {6'h14, 2'd2});
    check("multi_wr2", wr_log[2], {6'h1B, 2'd2});
    check("multi_wr3", wr_log[3], {6'h24, 2'd2});
    check("multi_wr4", wr_log[4], {6'h2D, 2'd2});
    check("multi_wr5", wr_log[5], {6'h1A, 2'd2});
    check("multi_wr6", wr_log[6], {6'h12, 2'd2});
    tick(); tick();
    check("multi_stray_go_busy", busy, 1'b0);
    check("multi_stray_go_nwr", wr_n, 7);

    // Reset asserted mid-FLIP on the row-0 bracket.
    clear_preset();
    for (int i = 1; i <= 6; i++) preset[i] = 2'd3;
    preset[7] = 2'd2;
    load_board();
    go = 1'b1; x = 3'd0; y = 3'd0; set_black = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (!wr_en && n < 200) begin
      tick();
      n++;
    end
    check("flip_reached", wr_en, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_flip_cnt", flip_cnt, 5'd0);
    check("midrst_wr_addr", wr_addr, 6'd0);
    tick(); tick();
    n = wr_n;
    resetn = 1'b1;
    tick();
    check("post_rst_wr_en", wr_en, 1'b0);
    check("post_rst_nwr", wr_n, n);
    check("post_rst_busy", busy, 1'b0);
    start_preset(); load_board();
    do_move(3'd3, 3'd2, 1'b1, 1'b0, cyc, seen, lg, fc, rd0);
    check("post_rst_done_seen", seen, 1'b1);
    check("post_rst_legal", lg, 1'b1);
    check("post_rst_flip_cnt", fc, 5'd1);
    check("post_rst_move_nwr", wr_n, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
